// File: rtl/seq_scan_scheduler_if.sv
// Bus between the requesters and the shared serial pattern-detector scheduler.
// The scheduler takes the slave side; the requester side is the master.
interface seq_scan_scheduler_if #(
   parameter int NREQ   = 4,
   parameter int ID_W   = 2,
   parameter int WORD_W = 16,
   parameter int PAT_W  = 5,
   parameter int CNT_W  = 5
);
   logic                     cfg_we;
   logic [PAT_W-1:0]         cfg_pat;
   logic [NREQ-1:0]          req;
   logic [NREQ*WORD_W-1:0]   data;
   logic [NREQ-1:0]          gnt;
   logic                     busy;
   logic                     ser_bit;
   logic                     hit;
   logic                     done;
   logic [ID_W-1:0]          done_id;
   logic [CNT_W-1:0]         match_cnt;

   modport master (
      output cfg_we, cfg_pat, req, data,
      input  gnt, busy, ser_bit, hit, done, done_id, match_cnt
   );

   modport slave (
      input  cfg_we, cfg_pat, req, data,
      output gnt, busy, ser_bit, hit, done, done_id, match_cnt
   );
endinterface

// File: rtl/seq_scan_scheduler.sv
// Round-robin scheduler sharing one serial Mealy pattern detector among NREQ requesters;
// each granted word is shifted MSB-first and overlapping pattern matches are counted.
module seq_scan_scheduler #(
   parameter int             NREQ    = 4,
   parameter int             ID_W    = 2,
   parameter int             WORD_W  = 16,
   parameter int             PAT_W   = 5,
   parameter int             CNT_W   = 5,
   parameter logic [PAT_W-1:0] PAT_RST = 5'b10101
) (
   input logic                clk,
   input logic                reset,
   seq_scan_scheduler_if.slave bus
);
   localparam int KW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, SHIFT, REPORT} state_t;

   state_t             state;
   logic [PAT_W-1:0]   pat;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    win_id;
   logic               found;
   logic [WORD_W-1:0]  word;
   logic [PAT_W-2:0]   hist;
   logic [KW-1:0]      k;
   logic [CNT_W-1:0]   cnt;
   logic [PAT_W-1:0]   win;
   logic               ser;
   logic               hit;
   logic [NREQ-1:0]    gnt_r;
   logic               busy_r;
   logic               done_r;
   logic [ID_W-1:0]    done_id_r;
   logic [CNT_W-1:0]   match_cnt_r;

   // Scan upward from the last winner so every requester gets a turn.
   always_comb begin
      win_id = ptr;
      found  = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         if (!found && bus.req[(int'(ptr) + i) % NREQ]) begin
            found  = 1'b1;
            win_id = ID_W'((int'(ptr) + i) % NREQ);
         end
      end
   end

   assign ser = (state == SHIFT) ? word[WORD_W-1] : 1'b0;
   assign win = {hist, ser};
   // Mealy output: the window is only meaningful once PAT_W bits of this word have arrived.
   assign hit = (state == SHIFT) && (int'(k) >= PAT_W - 1) && (win == pat);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pat         <= PAT_RST;
         ptr         <= ID_W'(NREQ - 1);
         word        <= '0;
         hist        <= '0;
         k           <= '0;
         cnt         <= '0;
         gnt_r       <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         done_id_r   <= '0;
         match_cnt_r <= '0;
      end else begin
         gnt_r  <= '0;
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cfg_we) pat <= bus.cfg_pat;
               if (found) begin
                  state  <= GRANT;
                  ptr    <= win_id;
                  gnt_r  <= {{(NREQ-1){1'b0}}, 1'b1} << win_id;
                  busy_r <= 1'b1;
               end
            end
            GRANT: begin
               word  <= bus.data[ptr*WORD_W +: WORD_W];
               hist  <= '0;
               k     <= '0;
               cnt   <= '0;
               state <= SHIFT;
            end
            SHIFT: begin
               word <= word << 1;
               hist <= win[PAT_W-2:0];
               k    <= k + 1'b1;
               if (hit) cnt <= cnt + 1'b1;
               if (k == KW'(WORD_W - 1)) begin
                  state       <= REPORT;
                  done_r      <= 1'b1;
                  done_id_r   <= ptr;
                  match_cnt_r <= cnt + CNT_W'(hit);
               end
            end
            REPORT: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt       = gnt_r;
   assign bus.busy      = busy_r;
   assign bus.ser_bit   = ser;
   assign bus.hit       = hit;
   assign bus.done      = done_r;
   assign bus.done_id   = done_id_r;
   assign bus.match_cnt = match_cnt_r;
endmodule

// File: tb/tb_seq_scan_scheduler.sv
// Scoreboard bench for seq_scan_scheduler: stimulus queues expected grants/results,
// a monitor pops and compares on every gnt and done.
module tb_seq_scan_scheduler;
   localparam int NREQ = 4, ID_W = 2, WORD_W = 16, PAT_W = 5, CNT_W = 5;

   typedef struct {int id; int cnt;} res_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   seq_scan_scheduler_if #(.NREQ(NREQ), .ID_W(ID_W), .WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) bus();

   seq_scan_scheduler #(.NREQ(NREQ), .ID_W(ID_W), .WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W),
                        .PAT_RST(5'b10101)) dut (.clk(clk), .reset(reset), .bus(bus));

   res_t exp_q[$];
   int   gnt_q[$];
   int   n_cmp = 0, n_fail = 0;
   int   cyc = 0;
   int   gnt_cyc = 0, done_cyc = 0, hits = 0, sh_k = 0, last_hit_k = -1, n_done = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin : mon
      int   e;
      res_t r;
      #1;
      if (reset) begin
         if (bus.gnt != '0) begin
            gnt_cyc = cyc; hits = 0; sh_k = 0; last_hit_k = -1;
            chk("gnt_serhit_quiet", {bus.ser_bit, bus.hit}, 0);
            if (gnt_q.size() == 0) chk("unexpected_gnt", bus.gnt, 0);
            else begin
               e = gnt_q.pop_front();
               chk("gnt_onehot", bus.gnt, 1 << e);
            end
         end else if (bus.busy && !bus.done) begin
            if (bus.hit) begin hits++; last_hit_k = sh_k; end
            sh_k++;
         end
         if (bus.done) begin
            done_cyc = cyc; n_done++;
            chk("done_serhit_quiet", {bus.ser_bit, bus.hit}, 0);
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               r = exp_q.pop_front();
               chk("done_id", bus.done_id, r.id);
               chk("match_cnt", bus.match_cnt, r.cnt);
               chk("hit_pulses", hits, r.cnt);
            end
         end
      end
   end

   task automatic wait_gnt(input int id);
      int n = 0;
      do begin @(negedge clk); n++; end while (!bus.gnt[id] && n < 200);
      if (!bus.gnt[id]) chk("gnt_timeout", 0, 1);
   endtask

   task automatic wait_any_gnt();
      int n = 0;
      do begin @(negedge clk); n++; end while (bus.gnt == '0 && n < 200);
      if (bus.gnt == '0) chk("gnt_timeout", 0, 1);
   endtask

   task automatic wait_done();
      int n = 0;
      do begin @(negedge clk); n++; end while (!bus.done && n < 200);
      if (!bus.done) chk("done_timeout", 0, 1);
   endtask

   task automatic do_word(input int id, input logic [15:0] w, input int exp_cnt,
                          input bit wcfg, input logic [4:0] p, output int t0);
      @(negedge clk);
      bus.data[id*WORD_W +: WORD_W] = w;
      bus.req[id] = 1'b1;
      if (wcfg) begin bus.cfg_we = 1'b1; bus.cfg_pat = p; end
      t0 = cyc;
      gnt_q.push_back(id);
      exp_q.push_back('{id: id, cnt: exp_cnt});
      wait_gnt(id);
      bus.req[id] = 1'b0;
      bus.cfg_we = 1'b0;
      wait_done();
   endtask

   task automatic write_pat(input logic [4:0] p);
      @(negedge clk); bus.cfg_we = 1'b1; bus.cfg_pat = p;
      @(negedge clk); bus.cfg_we = 1'b0;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_gnt"}, bus.gnt, 0);
      chk({nm, "_busy"}, bus.busy, 0);
      chk({nm, "_done"}, bus.done, 0);
      chk({nm, "_done_id"}, bus.done_id, 0);
      chk({nm, "_match_cnt"}, bus.match_cnt, 0);
      chk({nm, "_ser_bit"}, bus.ser_bit, 0);
      chk({nm, "_hit"}, bus.hit, 0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int t0, snap;
      bus.cfg_we = 1'b0; bus.cfg_pat = '0; bus.req = '0; bus.data = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b1;

      // T3: all requesters held; pointer starts so that req0 wins first
      @(negedge clk);
      bus.data = {16'h0015, 16'hAAAA, 16'hFFFF, 16'hA800};
      bus.req  = 4'b1111;
      gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(2); gnt_q.push_back(3); gnt_q.push_back(0);
      exp_q.push_back('{id: 0, cnt: 1}); exp_q.push_back('{id: 1, cnt: 0});
      exp_q.push_back('{id: 2, cnt: 6}); exp_q.push_back('{id: 3, cnt: 1});
      exp_q.push_back('{id: 0, cnt: 1});
      for (int g = 0; g < 5; g++) wait_any_gnt();
      bus.req = '0;
      wait_done();

      // T1: latency and overlapping count
      do_word(0, 16'h5555, 6, 1'b0, 5'b0, t0);
      chk("t1_gnt_latency", gnt_cyc - t0, 1);
      chk("t1_done_latency", done_cyc - t0, 18);

      // T4: single match at k=4
      do_word(1, 16'hA800, 1, 1'b0, 5'b0, t0);
      chk("t4_hit_k", last_hit_k, 4);

      // T2: programmed pattern
      do_word(2, 16'hFFFF, 0, 1'b0, 5'b0, t0);
      write_pat(5'b11111);
      do_word(2, 16'hFFFF, 12, 1'b0, 5'b0, t0);
      write_pat(5'b10101);

      // T5: config during SHIFT is dropped; config with req in IDLE applies to that word
      @(negedge clk);
      bus.data[0 +: WORD_W] = 16'h5555; bus.req[0] = 1'b1;
      gnt_q.push_back(0); exp_q.push_back('{id: 0, cnt: 6});
      wait_gnt(0);
      bus.req[0] = 1'b0;
      repeat (3) @(negedge clk);
      bus.cfg_we = 1'b1; bus.cfg_pat = 5'b11111;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      wait_done();
      do_word(3, 16'hFFFF, 0, 1'b0, 5'b0, t0);
      do_word(3, 16'hFFFF, 12, 1'b1, 5'b11111, t0);

      // T6: reset at SHIFT k=7 aborts; pattern returns to reset value
      @(negedge clk);
      bus.data[0 +: WORD_W] = 16'h5555; bus.req[0] = 1'b1;
      gnt_q.push_back(0);
      wait_gnt(0);
      bus.req[0] = 1'b0;
      repeat (8) @(negedge clk);
      chk("t6_busy_before_reset", bus.busy, 1);
      snap = n_done;
      reset = 1'b0;
      #1;
      chk_all_zero("t6_async");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      chk("t6_no_done", n_done, snap);
      do_word(0, 16'h5555, 6, 1'b0, 5'b0, t0);

      repeat (3) @(negedge clk);
      chk("gnt_queue_drained", gnt_q.size(), 0);
      chk("result_queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
